pulse_cmd_decoder: RTL and testbench
====================================

// Module: pulse_cmd_decoder
// PURPOSE
//  Upstream of pulse_gen/pulses. Takes bytes from the UART receiver, assembles 5-byte command frames,
//  and keeps the pulse parameter register file that drives pulses.
//  Computes derived timing words, updates all outputs atomically, and returns a 1-byte ack to the UART transmitter.
// PARAMETERS
//  TIMEOUT_CYC   120000   max clk cycles between bytes of one frame (10 ms @ 12 MHz)
//  DEF_PERIOD    20000    reset value of period
//  DEF_P1WIDTH   30       reset p1width and pbwidth
//  DEF_P2WIDTH   60       reset p2width
//  DEF_DELAY     200      reset delay
//  DEF_ATT_DELAY 2000     reset att_delay (internal)
//  DEF_OFFRES    500      reset offres_input (internal)
// PORTS
//  clk            in   1   12 MHz system clock
//  reset          in   1   synchronous, active-high
//  rx_data        in   8   received byte
//  rx_valid       in   1   1-cycle strobe: rx_data valid
//  tx_data        out  8   ack byte
//  tx_valid       out  1   ack pending; held until tx_ready
//  tx_ready       in   1   transmitter accepts tx_data when tx_valid&tx_ready
//  period, p1width, p2width, pbwidth, delay, p2start, sync_up, att_down, offres_delay   out  32 each
//  pump, double, block   out  1 each
//  pulse_block    out  8
//  pp_pump, pp_probe, post_att   out  7 each
//  cfg_update     out  1   1-cycle strobe after outputs change
//  err_count      out  8   saturating count of bad/timed-out frames
// BEHAVIOUR
//  Reset: outputs = DEF_* (pbwidth=DEF_P1WIDTH); pump=1, double=1, block=1, pulse_block=50,
//    pp_pump=7'h00, pp_probe=post_att=7'h7F; derived words recomputed from defaults;
//    tx_valid=0, cfg_update=0, err_count=0; FSM=IDLE. Reset mid-frame discards the partial frame.
//  Frame: CMD byte, then D3..D0 (MSB first) giving 32-bit word W.
//  Opcodes: 01 period, 02 p1width, 03 p2width, 04 delay, 05 pbwidth, 06 offres_input, 07 pulse_block=W[7:0],
//    08 {block,double,pump}=W[2:0], 09 pp_pump=W[6:0], pp_probe=W[14:8], post_att=W[22:16], 0A att_delay.
//  FSM:
//    IDLE   : rx_valid -> latch CMD, cnt=0, -> PAYLOAD.
//    PAYLOAD: rx_valid shifts byte into W, cnt++. After the 4th byte -> APPLY.
//             Idle timer reaches TIMEOUT_CYC -> discard, err_count++, -> IDLE. Timer clears on every byte.
//    APPLY  : one cycle. Writes the base register, and all derived words update on the same edge.
//             cfg_update is high the following cycle. -> IDLE.
//             An rx_valid arriving in APPLY is accepted as the next CMD byte and is never dropped.
//  Derived words (mod 2^32, from post-write base values):
//    p2start  = p1width + delay
//    sync_up  = p2start + p2width
//    att_down = sync_up + att_delay
//    offres_delay = period - offres_input - p1width, clamped to 0 if negative.
//  Unknown opcode: payload is consumed, no register changes, no cfg_update, err_count++, ack=8'hEE.
//  Ack: after APPLY, tx_data = CMD (or 8'hEE) and tx_valid=1 until the tx_valid&tx_ready edge.
//    If the previous ack is still pending, the new ack is dropped; the register write still happens.
//  Latency: last payload byte at edge E -> outputs change at E+1 -> cfg_update high in the cycle after E+1.
//  err_count saturates at 255.
// STRUCTURE
//  pulse_cmd_defs.vh: opcode localparams, ACK_ERR=8'hEE, and default pulse_block/attenuator values.
//  Sub-module cmd_frame_rx: byte assembly, idle timer, timeout.
//    Outputs: frm_valid (1-cycle), frm_cmd[7:0], frm_word[31:0], frm_timeout.
//  The top holds the register file, derived arithmetic, and the ack register.
// TESTING
//  1 Reset -> period=20000, p2start=230, sync_up=290, att_down=2290, offres_delay=19470, tx_valid=0.
//  2 Send 01 00 00 9C 40 -> period=40000 and offres_delay=39470 on the same edge;
//    cfg_update 1 cycle; tx_data=01.
//  3 Send 02 00 00 00 64 -> p1width=100, p2start=300, sync_up=360, att_down=2360; pbwidth unchanged.
//  4 Send 06 FF FF FF FF -> offres_delay=0 (clamped).
//    Send 3 bytes then idle TIMEOUT_CYC cycles -> no change, err_count=1; the next full frame applies normally.
//  5 Send opcode 7F with 4 bytes -> no register change, tx_data=EE.
//    Send two frames back-to-back with tx_ready=0 -> both applied, only the first ack is seen.
//  6 Assert reset after CMD+2 bytes -> defaults restored; the following frame decodes correctly.
//    A CMD byte arriving in the APPLY cycle is decoded as a new frame.

Source files
------------

// File: rtl/pulse_cmd_decoder_pkg.sv
// Shared definitions for the pulse command decoder: opcodes, ack codes,
// reset values of the non-timing registers and the frame FSM state type.
package pulse_cmd_decoder_pkg;

    localparam logic [7:0] OP_PERIOD      = 8'h01;
    localparam logic [7:0] OP_P1WIDTH     = 8'h02;
    localparam logic [7:0] OP_P2WIDTH     = 8'h03;
    localparam logic [7:0] OP_DELAY       = 8'h04;
    localparam logic [7:0] OP_PBWIDTH     = 8'h05;
    localparam logic [7:0] OP_OFFRES      = 8'h06;
    localparam logic [7:0] OP_PULSE_BLOCK = 8'h07;
    localparam logic [7:0] OP_FLAGS       = 8'h08;
    localparam logic [7:0] OP_ATTEN       = 8'h09;
    localparam logic [7:0] OP_ATT_DELAY   = 8'h0A;

    localparam logic [7:0] ACK_ERR        = 8'hEE;

    localparam logic [7:0] DEF_PULSE_BLOCK = 8'd50;
    localparam logic [6:0] DEF_PP_PUMP     = 7'h00;
    localparam logic [6:0] DEF_PP_PROBE    = 7'h7F;
    localparam logic [6:0] DEF_POST_ATT    = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_APPLY   = 2'd2
    } frame_state_t;

    // Opcodes are a contiguous range 01..0A.
    function automatic logic opcode_known(input logic [7:0] cmd);
        return (cmd >= OP_PERIOD) && (cmd <= OP_ATT_DELAY);
    endfunction

endpackage

// File: rtl/pulse_cmd_decoder_cmd_frame_rx.sv
// Assembles CMD + four payload bytes (MSB first) into one frame and
// abandons a frame whose bytes are spaced more than TIMEOUT_CYC apart.
// frm_valid is high for the single APPLY cycle; frm_cmd/frm_word are
// stable during it. A byte arriving in APPLY starts the next frame.
module cmd_frame_rx
    import pulse_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 120000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         frm_valid,
    output logic [7:0]   frm_cmd,
    output logic [31:0]  frm_word,
    output logic         frm_timeout,
    output frame_state_t frm_state
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    frame_state_t r_state;
    frame_state_t w_next_state;
    logic [7:0]   r_cmd;
    logic [31:0]  r_word;
    logic [1:0]   r_cnt;
    logic [31:0]  r_timer;
    logic         w_timeout;

    // Next-state decode and the timeout strobe.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) w_next_state = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (r_cnt == 2'd3) w_next_state = ST_APPLY;
                end else if (r_timer == TMO_LAST) begin
                    w_next_state = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_APPLY: begin
                w_next_state = rx_valid ? ST_PAYLOAD : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register, byte capture, payload shift and idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= 8'h00;
            r_word  <= 32'h0;
            r_cnt   <= 2'd0;
            r_timer <= 32'h0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE, ST_APPLY: begin
                    if (rx_valid) begin
                        r_cmd   <= rx_data;
                        r_cnt   <= 2'd0;
                        r_timer <= 32'h0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        r_word  <= {r_word[23:0], rx_data};
                        r_cnt   <= r_cnt + 2'd1;
                        r_timer <= 32'h0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign frm_valid   = (r_state == ST_APPLY);
    assign frm_cmd     = r_cmd;
    assign frm_word    = r_word;
    assign frm_timeout = w_timeout;
    assign frm_state   = r_state;

endmodule

// File: rtl/pulse_cmd_decoder.sv
// Pulse parameter register file fed by UART command frames. All base
// registers and the derived timing words are written on the same edge so
// downstream pulse logic never sees a half-updated set. Returns a one-byte
// ack (opcode, or EE for an unknown opcode).
// tx handshake: tx_valid rises with a new ack and stays high, with tx_data
// stable, until the edge where tx_valid && tx_ready; a new ack arriving
// while one is still pending is dropped.
module pulse_cmd_decoder
    import pulse_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC   = 120000,
    parameter int unsigned DEF_PERIOD    = 20000,
    parameter int unsigned DEF_P1WIDTH   = 30,
    parameter int unsigned DEF_P2WIDTH   = 60,
    parameter int unsigned DEF_DELAY     = 200,
    parameter int unsigned DEF_ATT_DELAY = 2000,
    parameter int unsigned DEF_OFFRES    = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] period,
    output logic [31:0] p1width,
    output logic [31:0] p2width,
    output logic [31:0] pbwidth,
    output logic [31:0] delay,
    output logic [31:0] p2start,
    output logic [31:0] sync_up,
    output logic [31:0] att_down,
    output logic [31:0] offres_delay,
    output logic        pump,
    output logic        double,
    output logic        block,
    output logic [7:0]  pulse_block,
    output logic [6:0]  pp_pump,
    output logic [6:0]  pp_probe,
    output logic [6:0]  post_att,
    output logic        cfg_update,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] DEF_P2START  = 32'(DEF_P1WIDTH + DEF_DELAY);
    localparam logic [31:0] DEF_SYNC_UP  = 32'(DEF_P1WIDTH + DEF_DELAY + DEF_P2WIDTH);
    localparam logic [31:0] DEF_ATT_DOWN = 32'(DEF_P1WIDTH + DEF_DELAY + DEF_P2WIDTH + DEF_ATT_DELAY);
    localparam logic [31:0] DEF_OFF_DLY  =
        (DEF_PERIOD >= DEF_OFFRES + DEF_P1WIDTH) ? 32'(DEF_PERIOD - DEF_OFFRES - DEF_P1WIDTH) : 32'h0;

    logic         w_frm_valid;
    logic [7:0]   w_frm_cmd;
    logic [31:0]  w_frm_word;
    logic         w_frm_timeout;
    frame_state_t w_frm_state;

    cmd_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frm_valid   (w_frm_valid),
        .frm_cmd     (w_frm_cmd),
        .frm_word    (w_frm_word),
        .frm_timeout (w_frm_timeout),
        .frm_state   (w_frm_state)
    );

    logic [31:0] r_period, r_p1width, r_p2width, r_pbwidth, r_delay;
    logic [31:0] r_att_delay, r_offres;
    logic [31:0] r_p2start, r_sync_up, r_att_down, r_offres_delay;
    logic        r_pump, r_double, r_block;
    logic [7:0]  r_pulse_block;
    logic [6:0]  r_pp_pump, r_pp_probe, r_post_att;
    logic        r_cfg_update;
    logic [7:0]  r_err_count;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;

    logic [31:0] w_period, w_p1width, w_p2width, w_pbwidth, w_delay;
    logic [31:0] w_att_delay, w_offres;
    logic [31:0] w_p2start, w_sync_up, w_att_down, w_offres_delay;
    logic        w_pump, w_double, w_block;
    logic [7:0]  w_pulse_block;
    logic [6:0]  w_pp_pump, w_pp_probe, w_post_att;
    logic [33:0] w_off_diff;
    logic        w_known;

    // Post-write base values and the derived words computed from them.
    always_comb begin
        w_period      = r_period;
        w_p1width     = r_p1width;
        w_p2width     = r_p2width;
        w_pbwidth     = r_pbwidth;
        w_delay       = r_delay;
        w_att_delay   = r_att_delay;
        w_offres      = r_offres;
        w_pump        = r_pump;
        w_double      = r_double;
        w_block       = r_block;
        w_pulse_block = r_pulse_block;
        w_pp_pump     = r_pp_pump;
        w_pp_probe    = r_pp_probe;
        w_post_att    = r_post_att;
        w_known       = opcode_known(w_frm_cmd);
        if (w_frm_valid) begin
            case (w_frm_cmd)
                OP_PERIOD:      w_period      = w_frm_word;
                OP_P1WIDTH:     w_p1width     = w_frm_word;
                OP_P2WIDTH:     w_p2width     = w_frm_word;
                OP_DELAY:       w_delay       = w_frm_word;
                OP_PBWIDTH:     w_pbwidth     = w_frm_word;
                OP_OFFRES:      w_offres      = w_frm_word;
                OP_PULSE_BLOCK: w_pulse_block = w_frm_word[7:0];
                OP_FLAGS:       {w_block, w_double, w_pump} = w_frm_word[2:0];
                OP_ATTEN: begin
                    w_pp_pump  = w_frm_word[6:0];
                    w_pp_probe = w_frm_word[14:8];
                    w_post_att = w_frm_word[22:16];
                end
                OP_ATT_DELAY:   w_att_delay   = w_frm_word;
                default: ;
            endcase
        end
        w_p2start  = w_p1width + w_delay;
        w_sync_up  = w_p2start + w_p2width;
        w_att_down = w_sync_up + w_att_delay;
        // 34-bit difference: bit 33 set means the result went negative.
        w_off_diff = {2'b00, w_period} - {2'b00, w_offres} - {2'b00, w_p1width};
        w_offres_delay = w_off_diff[33] ? 32'h0 : w_off_diff[31:0];
    end

    // Register file, derived words, error counter and ack register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period       <= 32'(DEF_PERIOD);
            r_p1width      <= 32'(DEF_P1WIDTH);
            r_p2width      <= 32'(DEF_P2WIDTH);
            r_pbwidth      <= 32'(DEF_P1WIDTH);
            r_delay        <= 32'(DEF_DELAY);
            r_att_delay    <= 32'(DEF_ATT_DELAY);
            r_offres       <= 32'(DEF_OFFRES);
            r_p2start      <= DEF_P2START;
            r_sync_up      <= DEF_SYNC_UP;
            r_att_down     <= DEF_ATT_DOWN;
            r_offres_delay <= DEF_OFF_DLY;
            r_pump         <= 1'b1;
            r_double       <= 1'b1;
            r_block        <= 1'b1;
            r_pulse_block  <= DEF_PULSE_BLOCK;
            r_pp_pump      <= DEF_PP_PUMP;
            r_pp_probe     <= DEF_PP_PROBE;
            r_post_att     <= DEF_POST_ATT;
            r_cfg_update   <= 1'b0;
            r_err_count    <= 8'h00;
            r_tx_data      <= 8'h00;
            r_tx_valid     <= 1'b0;
        end else begin
            r_period       <= w_period;
            r_p1width      <= w_p1width;
            r_p2width      <= w_p2width;
            r_pbwidth      <= w_pbwidth;
            r_delay        <= w_delay;
            r_att_delay    <= w_att_delay;
            r_offres       <= w_offres;
            r_p2start      <= w_p2start;
            r_sync_up      <= w_sync_up;
            r_att_down     <= w_att_down;
            r_offres_delay <= w_offres_delay;
            r_pump         <= w_pump;
            r_double       <= w_double;
            r_block        <= w_block;
            r_pulse_block  <= w_pulse_block;
            r_pp_pump      <= w_pp_pump;
            r_pp_probe     <= w_pp_probe;
            r_post_att     <= w_post_att;
            r_cfg_update   <= w_frm_valid && w_known;
            if (((w_frm_valid && !w_known) || w_frm_timeout) && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
            if (r_tx_valid && tx_ready)
                r_tx_valid <= 1'b0;
            if (w_frm_valid && (!r_tx_valid || tx_ready)) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_known ? w_frm_cmd : ACK_ERR;
            end
        end
    end

    assign period       = r_period;
    assign p1width      = r_p1width;
    assign p2width      = r_p2width;
    assign pbwidth      = r_pbwidth;
    assign delay        = r_delay;
    assign p2start      = r_p2start;
    assign sync_up      = r_sync_up;
    assign att_down     = r_att_down;
    assign offres_delay = r_offres_delay;
    assign pump         = r_pump;
    assign double       = r_double;
    assign block        = r_block;
    assign pulse_block  = r_pulse_block;
    assign pp_pump      = r_pp_pump;
    assign pp_probe     = r_pp_probe;
    assign post_att     = r_post_att;
    assign cfg_update   = r_cfg_update;
    assign err_count    = r_err_count;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign dbg_state    = w_frm_state;

endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// Directed bench for pulse_cmd_decoder. Inputs change on the falling edge,
// outputs are sampled on the falling edge; expected values are hand-computed.
module tb_pulse_cmd_decoder;

    localparam int unsigned TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] period, p1width, p2width, pbwidth, delay;
    logic [31:0] p2start, sync_up, att_down, offres_delay;
    logic        pump, double, block;
    logic [7:0]  pulse_block;
    logic [6:0]  pp_pump, pp_probe, post_att;
    logic        cfg_update;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    pulse_cmd_decoder #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .period       (period),
        .p1width      (p1width),
        .p2width      (p2width),
        .pbwidth      (pbwidth),
        .delay        (delay),
        .p2start      (p2start),
        .sync_up      (sync_up),
        .att_down     (att_down),
        .offres_delay (offres_delay),
        .pump         (pump),
        .double       (double),
        .block        (block),
        .pulse_block  (pulse_block),
        .pp_pump      (pp_pump),
        .pp_probe     (pp_probe),
        .post_att     (post_att),
        .cfg_update   (cfg_update),
        .err_count    (err_count),
        .dbg_state    (dbg_state)
    );

    // 12 MHz-ish clock; the exact period does not matter to the checks.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic drive_frame(input logic [7:0] cmd, input logic [31:0] w);
        drive_byte(cmd);
        drive_byte(w[31:24]);
        drive_byte(w[23:16]);
        drive_byte(w[15:8]);
        drive_byte(w[7:0]);
    endtask

    // Frame, then stop driving; returns at the falling edge right after
    // the write edge (cfg_update high here).
    task automatic apply_frame(input logic [7:0] cmd, input logic [31:0] w);
        drive_frame(cmd, w);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic accept_ack();
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("tx_valid_after_accept", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        // 1: reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_period", period, 32'd20000);
        chk("rst_pbwidth", pbwidth, 32'd30);
        chk("rst_p2start", p2start, 32'd230);
        chk("rst_sync_up", sync_up, 32'd290);
        chk("rst_att_down", att_down, 32'd2290);
        chk("rst_offres_delay", offres_delay, 32'd19470);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_flags", 32'({block, double, pump}), 32'h7);
        chk("rst_pulse_block", 32'(pulse_block), 32'd50);
        chk("rst_atten", 32'({pp_pump, pp_probe, post_att}), 32'({7'h00, 7'h7F, 7'h7F}));
        chk("rst_err", 32'(err_count), 32'd0);

        // 2: period write, exact latency
        drive_frame(8'h01, 32'h0000_9C40);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("apply_cyc_period_old", period, 32'd20000);
        chk("apply_cyc_cfg_low", 32'(cfg_update), 32'd0);
        @(negedge clk);
        chk("period_40000", period, 32'd40000);
        chk("offres_delay_39470", offres_delay, 32'd39470);
        chk("cfg_update_high", 32'(cfg_update), 32'd1);
        chk("ack_valid_01", 32'(tx_valid), 32'd1);
        chk("ack_data_01", 32'(tx_data), 32'h01);
        @(negedge clk);
        chk("cfg_update_one_cycle", 32'(cfg_update), 32'd0);
        chk("ack_held", 32'(tx_valid), 32'd1);
        accept_ack();

        // 3: p1width write, derived chain
        apply_frame(8'h02, 32'd100);
        chk("p1width_100", p1width, 32'd100);
        chk("p2start_300", p2start, 32'd300);
        chk("sync_up_360", sync_up, 32'd360);
        chk("att_down_2360", att_down, 32'd2360);
        chk("pbwidth_unchanged", pbwidth, 32'd30);
        chk("offres_delay_39400", offres_delay, 32'd39400);
        accept_ack();

        // 4: clamp and timeout
        apply_frame(8'h06, 32'hFFFF_FFFF);
        chk("offres_clamped", offres_delay, 32'd0);
        accept_ack();
        drive_byte(8'h01);
        drive_byte(8'h00);
        drive_byte(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (TMO + 5) @(negedge clk);
        chk("timeout_period_kept", period, 32'd40000);
        chk("timeout_err_1", 32'(err_count), 32'd1);
        chk("timeout_no_ack", 32'(tx_valid), 32'd0);
        chk("timeout_state_idle", 32'(dbg_state), 32'd0);
        apply_frame(8'h04, 32'd256);
        chk("delay_256", delay, 32'd256);
        chk("p2start_356", p2start, 32'd356);
        chk("att_down_2416", att_down, 32'd2416);
        accept_ack();

        // 5: unknown opcode, then ack drop under backpressure
        apply_frame(8'h7F, 32'h0000_0005);
        chk("bad_op_ack", 32'(tx_data), 32'hEE);
        chk("bad_op_no_cfg", 32'(cfg_update), 32'd0);
        chk("bad_op_err_2", 32'(err_count), 32'd2);
        chk("bad_op_period", period, 32'd40000);
        chk("bad_op_delay", delay, 32'd256);
        accept_ack();
        apply_frame(8'h03, 32'd80);
        apply_frame(8'h05, 32'd40);
        chk("b2b_p2width", p2width, 32'd80);
        chk("b2b_sync_up_436", sync_up, 32'd436);
        chk("b2b_att_down_2436", att_down, 32'd2436);
        chk("b2b_pbwidth_40", pbwidth, 32'd40);
        chk("b2b_first_ack_kept", 32'(tx_data), 32'h03);
        accept_ack();

        // 6: reset mid-frame, then a clean frame
        drive_byte(8'h01);
        drive_byte(8'h00);
        drive_byte(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_period", period, 32'd20000);
        chk("mid_rst_p2start", p2start, 32'd230);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        apply_frame(8'h02, 32'd100);
        chk("post_rst_p1width", p1width, 32'd100);
        chk("post_rst_sync_up", sync_up, 32'd360);
        chk("post_rst_period", period, 32'd20000);
        accept_ack();

        // CMD byte in the APPLY cycle starts the next frame
        drive_frame(8'h09, 32'h0012_3456);
        drive_frame(8'h0A, 32'h0000_000A);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("atten_pp_pump", 32'(pp_pump), 32'h56);
        chk("atten_pp_probe", 32'(pp_probe), 32'h34);
        chk("atten_post_att", 32'(post_att), 32'h12);
        chk("att_delay_att_down_370", att_down, 32'd370);
        chk("apply_cmd_ack_first", 32'(tx_data), 32'h09);
        chk("apply_cmd_err", 32'(err_count), 32'd0);
        accept_ack();

        apply_frame(8'h08, 32'h0000_0002);
        chk("flags_010", 32'({block, double, pump}), 32'h2);
        accept_ack();
        apply_frame(8'h07, 32'h0000_00AA);
        chk("pulse_block_aa", 32'(pulse_block), 32'hAA);
        chk("pulse_block_ack", 32'(tx_data), 32'h07);
        accept_ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
